// File: rtl/seq_pkg.sv
// Shared definitions for the countdown sequencer.
//
// Contents:
//   seq_state_e     - sequencer FSM states (IDLE, LOAD, RUN, REPORT)
//   CNT_W_DEF       - default count width (must match the down-counter)
//   PRESCALE_W_DEF  - default per-request divider width
//   TICK_W_DEF      - default width of the issued-pulse counter (count width + 1)
//   tick_width()    - tick counter width for a given count width
package seq_pkg;

    localparam int CNT_W_DEF      = 3;
    localparam int PRESCALE_W_DEF = 4;

    // A request of N produces N+1 enable pulses, so one extra bit is needed
    // to hold the pulse count for the largest request.
    function automatic int tick_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

    localparam int TICK_W_DEF = tick_width(CNT_W_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_prescaler.sv
// Programmable prescaler for the countdown sequencer.
//
// Counts 0..div while enabled and raises tick for exactly the cycle in which
// the count equals div, wrapping back to 0 on that cycle. div=0 therefore
// ticks every enabled cycle; in general one tick per (div+1) enabled cycles.
//
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous, active-high reset
//   clear   in   1   synchronous clear of the count (restart a new period)
//   enable  in   1   count while high; tick is forced low when not enabled
//   div     in   W   divider minus one
//   tick    out  1   one-cycle pulse at count==div
module seq_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    assign tick = enable && (cnt_q == div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Command front-end for the 3-bit down-counter.
//
// Accepts a count request over valid/ready, loads the counter, paces its
// count enable through a per-request prescaler, waits for the counter's done
// flag and returns the number of enable pulses issued as a completion record.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high; a source holds valid and its payload stable until that edge and
// never withdraws it, a sink may raise or drop ready freely.
//
// Build option:
//   SEQ_AUTO_RELOAD_EN - when defined, a completion handshake with no new
//     request pending goes straight back to LOAD with the previously latched
//     count/div (periodic mode). A request presented during that handshake
//     is accepted instead (req_ready is high in REPORT while cmp_ready is).
//     When undefined, REPORT always returns to IDLE and req_ready is low
//     outside IDLE.
//
// Ports:
//   clk           in   1            clock, rising edge
//   reset         in   1            synchronous, active-high reset
//   req_valid     in   1            request present
//   req_ready     out  1            request can be accepted
//   req_count     in   CNT_W        value to load into the counter
//   req_div       in   PRESCALE_W   prescale divider minus one
//   abort         in   1            cancel a request in LOAD/RUN, no completion
//   cnt_count_to  out  CNT_W        counter count_to (latched request count)
//   cnt_load      out  1            counter load, one cycle per request
//   cnt_en        out  1            counter count enable
//   cnt_done      in   1            counter done flag
//   cmp_valid     out  1            completion record valid
//   cmp_ready     in   1            completion consumer ready
//   cmp_ticks     out  CNT_W+1      enable pulses issued for this request
//   busy          out  1            high in any state other than IDLE
//   dbg_state     out  2            current FSM state
module countdown_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CNT_W-1:0]      req_count,
    input  logic [PRESCALE_W-1:0] req_div,
    input  logic                  abort,
    output logic [CNT_W-1:0]      cnt_count_to,
    output logic                  cnt_load,
    output logic                  cnt_en,
    input  logic                  cnt_done,
    output logic                  cmp_valid,
    input  logic                  cmp_ready,
    output logic [CNT_W:0]        cmp_ticks,
    output logic                  busy,
    output seq_state_e            dbg_state
);

    localparam int TICK_W = tick_width(CNT_W);
    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    seq_state_e state, state_next;

    logic [CNT_W-1:0]      count_q, count_next;
    logic [PRESCALE_W-1:0] div_q, div_next;
    logic [TICK_W-1:0]     ticks_q, ticks_next;
    logic                  run_first_q, run_first_next;
    logic                  en_next;

    logic                  ready_q;
    logic                  busy_q;
    logic                  load_q;
    logic                  en_q;
    logic                  cmp_valid_q;

    logic                  accept;
    logic                  cmp_hs;
    logic                  presc_tick;
    logic [TICK_W-1:0]     tick_limit;

    // ------------------------------------------------------------------
    // Prescaler: restarted while loading, runs only in RUN.
    // ------------------------------------------------------------------
    seq_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LOAD),
        .enable (state == RUN),
        .div    (div_q),
        .tick   (presc_tick)
    );

`ifdef SEQ_AUTO_RELOAD_EN
    // A new request may replace the periodic reload during the completion
    // handshake, so ready follows cmp_ready while reporting.
    assign req_ready = ready_q || ((state == REPORT) && cmp_ready);
`else
    assign req_ready = ready_q;
`endif

    assign accept = req_valid && req_ready;
    assign cmp_hs = cmp_valid_q && cmp_ready;

    // The counter's done is registered, so it shows up one cycle after the
    // final enable. Capping issued pulses at count+1 keeps the prescaler from
    // slipping an extra enable into that gap when div is small.
    assign tick_limit = {1'b0, count_q} + TICK_W'(1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        count_next     = count_q;
        div_next       = div_q;
        ticks_next     = ticks_q;
        run_first_next = 1'b0;
        en_next        = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    count_next = req_count;
                    div_next   = req_div;
                    state_next = LOAD;
                end
            end

            LOAD: begin
                ticks_next = '0;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    run_first_next = 1'b1;
                    state_next     = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!run_first_q && cnt_done) begin
                    // done may still carry the previous request's value in
                    // the first RUN cycle, hence the run_first guard.
                    state_next = REPORT;
                end else if (presc_tick && (ticks_q < tick_limit)) begin
                    en_next    = 1'b1;
                    ticks_next = (ticks_q == TICK_MAX) ? ticks_q : ticks_q + 1'b1;
                end
            end

            REPORT: begin
                if (cmp_hs) begin
`ifdef SEQ_AUTO_RELOAD_EN
                    if (accept) begin
                        count_next = req_count;
                        div_next   = req_div;
                    end
                    state_next = LOAD;
`else
                    state_next = IDLE;
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Every output is decoded from the next
    // state so it lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count_q     <= '0;
            div_q       <= '0;
            ticks_q     <= '0;
            run_first_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            en_q        <= 1'b0;
            cmp_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            count_q     <= count_next;
            div_q       <= div_next;
            ticks_q     <= ticks_next;
            run_first_q <= run_first_next;
            ready_q     <= (state_next == IDLE);
            busy_q      <= (state_next != IDLE);
            load_q      <= (state_next == LOAD);
            en_q        <= en_next;
            cmp_valid_q <= (state_next == REPORT);
        end
    end

    assign cnt_count_to = count_q;
    assign cnt_load     = load_q;
    assign cnt_en       = en_q;
    assign cmp_valid    = cmp_valid_q;
    assign cmp_ticks    = ticks_q;
    assign busy         = busy_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer. A behavioural model of the downstream 3-bit
// down-counter supplies cnt_done; each request is judged against the simple
// rule "count N, divider D -> one load, N+1 enables spaced D+1 cycles apart,
// completion reporting N+1".
module tb_countdown_sequencer;
    import seq_pkg::*;

    localparam int CNT_W      = 3;
    localparam int PRESCALE_W = 4;
    localparam int TICK_W     = CNT_W + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [CNT_W-1:0]      req_count;
    logic [PRESCALE_W-1:0] req_div;
    logic                  abort;
    logic [CNT_W-1:0]      cnt_count_to;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  cnt_done;
    logic                  cmp_valid;
    logic                  cmp_ready;
    logic [CNT_W:0]        cmp_ticks;
    logic                  busy;
    seq_state_e            dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TICK_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    countdown_sequencer #(
        .CNT_W      (CNT_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_count    (req_count),
        .req_div      (req_div),
        .abort        (abort),
        .cnt_count_to (cnt_count_to),
        .cnt_load     (cnt_load),
        .cnt_en       (cnt_en),
        .cnt_done     (cnt_done),
        .cmp_valid    (cmp_valid),
        .cmp_ready    (cmp_ready),
        .cmp_ticks    (cmp_ticks),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- downstream counter model ----------------
    logic [CNT_W-1:0] m_val;
    logic             m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_val  <= '0;
            m_done <= 1'b0;
        end else if (cnt_load) begin
            m_val  <= cnt_count_to;
            m_done <= 1'b0;
        end else if (cnt_en) begin
            if (m_val == 0) m_done <= 1'b1;
            else            m_val  <= m_val - 1'b1;
        end
    end

    assign cnt_done = m_done;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cnt_load"},     cnt_load, 0);
        check({tag, "_cnt_en"},       cnt_en, 0);
        check({tag, "_cnt_count_to"}, cnt_count_to, 0);
        check({tag, "_cmp_valid"},    cmp_valid, 0);
        check({tag, "_cmp_ticks"},    cmp_ticks, 0);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_state"},        32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, req_ready, 1);
    endtask

    // One full request. keep=1 leaves req_valid high with (kn,kd) to check
    // that a request presented while busy is held off, not dropped.
    task automatic run_req(input int n, input int d, input int hold,
                           input bit keep, input int kn, input int kd);
        int loads, pulses, last_en, gap_bad, busy_take, got_cmp, stable_bad, budget;
        logic [TICK_W-1:0] exp;
        wait_ready("req_ready_wait");
        req_valid = 1'b1;
        req_count = CNT_W'(n);
        req_div   = PRESCALE_W'(d);
        exp_q.push_back(TICK_W'(n + 1));
        @(negedge clk);
        if (keep) begin
            req_count = CNT_W'(kn);
            req_div   = PRESCALE_W'(kd);
        end else begin
            req_valid = 1'b0;
        end
        loads = 0; pulses = 0; last_en = -1; gap_bad = 0; busy_take = 0; got_cmp = 0;
        budget = (n + 1) * (d + 1) + 20;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cnt_load) loads++;
            if (cnt_en) begin
                if (pulses > 0 && (cyc - last_en) != d + 1) gap_bad++;
                last_en = cyc;
                pulses++;
            end
            if (req_valid && req_ready) busy_take++;
            if (cmp_valid) begin
                got_cmp = 1;
                break;
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        check("cmp_valid_seen", got_cmp, 1);
        check("load_pulses", loads, 1);
        check("en_pulses", pulses, n + 1);
        check("en_spacing", gap_bad, 0);
        check("held_req_refused", busy_take, 0);
        check("cmp_ticks", cmp_ticks, exp);
        stable_bad = 0;
        cmp_ready  = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!cmp_valid || cmp_ticks != exp || cnt_load || cnt_en) stable_bad++;
        end
        check("cmp_hold_stable", stable_bad, 0);
        cmp_ready = 1'b1;
        @(negedge clk);
        cmp_ready = 1'b0;
        check("cmp_valid_drop", cmp_valid, 0);
        check("busy_after_cmp", busy, 0);
        check("ready_after_cmp", req_ready, 1);
    endtask

    // Request count=7, abort two cycles into RUN.
    task automatic run_abort();
        int bad;
        wait_ready("abort_ready_wait");
        req_valid = 1'b1;
        req_count = CNT_W'(7);
        req_div   = '0;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_load", cnt_load, 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_en_low", cnt_en, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmp_valid || cnt_en || cnt_load || busy) bad++;
        end
        check("abort_quiet", bad, 0);
    endtask

    task automatic run_reset_mid();
        wait_ready("rst_ready_wait");
        req_valid = 1'b1;
        req_count = CNT_W'(7);
        req_div   = PRESCALE_W'(2);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", req_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_count = '0;
        req_div   = '0;
        abort     = 1'b0;
        cmp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        check("por_ready_in_reset", req_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("por_ready", req_ready, 1);

`ifndef SEQ_AUTO_RELOAD_EN
        run_req(5, 0, 0, 1'b0, 0, 0);
        run_req(2, 3, 0, 1'b0, 0, 0);
        run_req(0, 0, 5, 1'b0, 0, 0);
        run_abort();
        run_reset_mid();
        run_req(3, 1, 0, 1'b1, 4, 0);
        run_req(4, 0, 1, 1'b0, 0, 0);
        run_req(7, 15, 0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_req($urandom_range(0, 7), $urandom_range(0, 15),
                    $urandom_range(0, 3), 1'b0, 0, 0);
        end
`else
        begin
            int loads, comps, cyc;
            wait_ready("auto_ready_wait");
            cmp_ready = 1'b1;
            req_valid = 1'b1;
            req_count = CNT_W'(1);
            req_div   = PRESCALE_W'(1);
            @(negedge clk);
            req_valid = 1'b0;
            loads = 0; comps = 0; cyc = 0;
            while (comps < 3 && cyc < 200) begin
                if (cnt_load) begin
                    loads++;
                    exp_q.push_back(TICK_W'(2));
                end
                if (cmp_valid) begin
                    comps++;
                    if (exp_q.size() == 0) check("auto_exp_avail", 0, 1);
                    else                   check("auto_ticks", cmp_ticks, exp_q.pop_front());
                end
                @(negedge clk);
                cyc++;
            end
            check("auto_completions", comps, 3);
            check("auto_loads", loads, 3);
            cyc = 0;
            while (!cnt_load && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("auto_reload_seen", cnt_load, 1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("auto_abort_busy", busy, 0);
            check("auto_abort_ready", req_ready, 1);
            cmp_ready = 1'b0;
            run_reset_mid();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
